// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 15;
    localparam int BANK_W  = 3;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 12'o4000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic flush;
        logic halt;
        logic ready;
    } ctrl_t;

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] p);
        return p + 12'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular FIFO with clear, occupancy count and full/empty flags
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ADDR_W + INSTR_W,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             rst_l,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign rdata   = mem[rd_ptr];

    // pointers and occupancy; clear drops every entry at once
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage is not reset; only slots between the pointers are ever presented
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    overflow_chk: assert property (@(posedge clock) disable iff (!rst_l) !(push && full && !clear));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with address tracking, flush/halt control and bank registers
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                QDEPTH   = 2
) (
    input  logic               clock,
    input  logic               rst_l,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid,
    input  logic               ready,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    input  logic               fb_we,
    input  logic               eb_we,
    input  logic [BANK_W-1:0]  bank_wdata,
    output logic [BANK_W-1:0]  bits_FB,
    output logic [BANK_W-1:0]  bits_EB
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QLIM = (CW + 1)'(QDEPTH);

    ctrl_t                       ctrl;
    fetch_state_t                state;
    fetch_state_t                state_next;
    logic [ADDR_W-1:0]           fetch_pc;
    logic [ADDR_W-1:0]           resp_pc;
    logic [INSTR_W+ADDR_W-1:0]   head;
    logic [CW-1:0]               outstanding;
    logic [CW-1:0]               q_count;
    logic [CW-1:0]               drop_cnt;
    logic [CW:0]                 in_flight;
    logic                        a_full;
    logic                        a_empty;
    logic                        q_full;
    logic                        q_empty;
    logic                        accept;
    logic                        resp_pop;
    logic                        keep_resp;

    assign ctrl      = '{flush, halt, ready};
    assign in_flight = {1'b0, outstanding} + {1'b0, q_count};
    // a flush cycle never issues, so a same-cycle acceptance cannot reach memory
    assign imem_req  = rst_l && state == RUN && !ctrl.flush && in_flight < QLIM && !a_full && !q_full;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ack;
    assign resp_pop  = imem_rvalid && !a_empty;
    assign keep_resp = resp_pop && drop_cnt == '0 && !ctrl.flush;
    assign valid     = !q_empty;
    assign instr     = valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : '0;
    assign pc        = valid ? head[ADDR_W-1:0] : '0;

    // flush wins over halt; only a flush leaves HALTED
    always_comb begin
        state_next = state;
        state_next = ctrl.flush ? RUN : (ctrl.halt ? HALTED : state);
    end

    // run state, fetch PC, stale-response counter and bank registers
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
            bits_FB  <= '0;
            bits_EB  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= ctrl.flush ? redirect_pc : (accept ? pc_next(fetch_pc) : fetch_pc);
            drop_cnt <= ctrl.flush ? outstanding - CW'(resp_pop)
                                   : drop_cnt - CW'(resp_pop && drop_cnt != '0);
            if (fb_we) bits_FB <= bank_wdata;
            if (eb_we) bits_EB <= bank_wdata;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ADDR_W)
    ) u_addr_fifo (
        .clock (clock),
        .rst_l (rst_l),
        .clear (1'b0),
        .push  (accept),
        .pop   (resp_pop),
        .wdata (fetch_pc),
        .rdata (resp_pc),
        .full  (a_full),
        .empty (a_empty),
        .count (outstanding)
    );

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_instr_queue (
        .clock (clock),
        .rst_l (rst_l),
        .clear (ctrl.flush),
        .push  (keep_resp),
        .pop   (valid && ctrl.ready),
        .wdata ({imem_rdata, resp_pc}),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

endmodule
